// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch queue with redirect flush of stale responses.
// Define PREFETCH_STATS_EN to add fetch/flush/drop statistic counters.
module instr_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed,
  output logic [31:0]     stat_dropped
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN   = ~XLEN'(3);
  localparam logic [XLEN-1:0] BOOT_PC = RESET_PC & ALIGN;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_d;

  logic [XLEN-1:0] fetch_pc;
  logic [AW-1:0]   head;
  logic [AW-1:0]   fill_ptr;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_d;
  logic [DEPTH-1:0] filled;

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];

  logic req_fire;
  logic pop;
  logic fill;
  logic discard;

  // reset gates the request so it drops the moment reset asserts
  assign imem_req_valid = reset
                        & (state == FETCH)
                        & ~redirect_valid
                        & (occ < FULL);
  assign imem_req_addr  = fetch_pc;

  assign out_valid = filled[head];
  assign out_pc    = out_valid ? pc_q[head]    : '0;
  assign out_instr = out_valid ? instr_q[head] : '0;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign pop      = out_valid & out_ready & ~redirect_valid;
  assign fill     = imem_rsp_valid
                  & (state == FETCH)
                  & ~redirect_valid;
  assign discard  = imem_rsp_valid & ~fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      drop_cnt <= '0;
    end else begin
      state    <= state_d;
      drop_cnt <= drop_d;
    end
  end

  // a response landing in the redirect cycle is already accounted for
  always_comb begin
    state_d = state;
    drop_d  = drop_cnt;
    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          drop_d = inflight - CW'(imem_rsp_valid);
          if (drop_d != '0) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_rsp_valid) begin
          drop_d = drop_cnt - CW'(1);
          if (drop_d == '0) state_d = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= BOOT_PC;
      head     <= '0;
      fill_ptr <= '0;
      tail     <= '0;
      occ      <= '0;
      inflight <= '0;
      filled   <= '0;
    end else begin
      inflight <= inflight
                + CW'(req_fire)
                - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ALIGN;
        head     <= '0;
        fill_ptr <= '0;
        tail     <= '0;
        occ      <= '0;
        filled   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          tail     <= tail + AW'(1);
        end
        if (fill) begin
          filled[fill_ptr] <= 1'b1;
          fill_ptr         <= fill_ptr + AW'(1);
        end
        if (pop) begin
          filled[head] <= 1'b0;
          head         <= head + AW'(1);
        end
        occ <= occ + CW'(req_fire) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_q[tail] <= fetch_pc;
    if (fill) instr_q[fill_ptr] <= imem_rsp_data;
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
      stat_dropped <= '0;
    end else begin
      if (req_fire)
        stat_fetched <= stat_fetched + 32'd1;
      if (redirect_valid)
        stat_flushed <= stat_flushed + 32'd1;
      if (discard)
        stat_dropped <= stat_dropped + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule
